ram_access_unit: RTL and testbench

- Upstream stage of the split even/odd-bank RAM.
- Accepts CPU-side 16-bit byte-addressed byte/word requests over a valid/ready handshake.
- Steers each request to the even (address bit 0 = 0) and odd bank ports: 15-bit word addresses, 8-bit data, synchronous read with 1-cycle latency.
- Returns one response per request, with lane reassembly and backpressure.

---
 rtl/ram_access_pkg.sv | 14 +
 rtl/ram_access_unit_if.sv | 31 +++
 rtl/ram_lane_steer.sv | 16 +
 rtl/ram_access_unit.sv | 104 ++++++++++
 tb/tb_ram_access_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared types and helpers for the split even/odd-bank RAM access unit
package ram_access_pkg;
    typedef enum logic {BYTE = 1'b0, WORD = 1'b1} width_e;
    typedef struct packed {
        logic   valid;
        logic   write;
        width_e width;
        logic   lsb;
        logic   err;
    } s1_tag_t;
    function automatic logic [15:0] ram_base(input int unsigned size);
        return 16'(32'h4000 - size);
    endfunction
endpackage

// File: rtl/ram_access_unit_if.sv
// ram_access_unit_if: CPU-side request/response handshake (master = CPU, slave = access unit)
// Ports: req_valid/req_ready/req_addr/req_write/req_word/req_wdata, resp_valid/resp_ready/resp_rdata,
// resp_err only when RAM_RANGE_CHECK_EN is defined
interface ram_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
`ifdef RAM_RANGE_CHECK_EN
    logic        resp_err;
`endif
    modport master (
        output req_valid, req_addr, req_write, req_word, req_wdata, resp_ready,
`ifdef RAM_RANGE_CHECK_EN
        input resp_err,
`endif
        input req_ready, resp_valid, resp_rdata
    );
    modport slave (
        input req_valid, req_addr, req_write, req_word, req_wdata, resp_ready,
`ifdef RAM_RANGE_CHECK_EN
        output resp_err,
`endif
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/ram_lane_steer.sv
// ram_lane_steer: byte-lane swap plus zero-extension
// Ports: swap_i exchanges lanes, word_i keeps the high byte, kill_i forces zero,
// a_i/b_i are the low/high input lanes, y_o the steered 16-bit result
module ram_lane_steer (
    input  logic        swap_i,
    input  logic        word_i,
    input  logic        kill_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] y_o
);
    logic [7:0] lo, hi;
    assign lo  = swap_i ? b_i : a_i;
    assign hi  = swap_i ? a_i : b_i;
    assign y_o = kill_i ? 16'h0000 : word_i ? {hi, lo} : {8'h00, lo};
endmodule

// File: rtl/ram_access_unit.sv
// ram_access_unit: steers CPU byte/word requests onto even/odd RAM banks and reassembles responses
// Ports: clk, reset (sync, active high), bus (CPU handshake, slave side),
// read_addr_*/read_data_* bank read ports, write_addr_*/write_data_*/write_en_* bank write ports
// Option: RAM_RANGE_CHECK_EN flags out-of-range accesses on resp_err instead of aliasing modulo SIZE
module ram_access_unit
    import ram_access_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    ram_access_unit_if.slave bus,
    output logic [14:0] read_addr_even,
    output logic [14:0] read_addr_odd,
    input  logic [7:0]  read_data_even,
    input  logic [7:0]  read_data_odd,
    output logic [14:0] write_addr_even,
    output logic [14:0] write_addr_odd,
    output logic [7:0]  write_data_even,
    output logic [7:0]  write_data_odd,
    output logic        write_en_even,
    output logic        write_en_odd
);
    localparam logic [15:0] RAMBASE = ram_base(SIZE);
    localparam int AW = $clog2(SIZE) - 1;

    s1_tag_t     s1_q, s1_d;
    logic [14:0] hold_even_q, hold_odd_q;
    logic [14:0] addr_even, addr_odd;
    logic [15:0] a1, off_even, off_odd, wsteer;
    logic        accept, err;

    assign bus.req_ready = !reset && (!s1_q.valid || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // odd bank always holds A's word; even bank holds (A+1)'s word for word accesses
    assign a1        = bus.req_addr + 16'd1;
    assign off_odd   = bus.req_addr - RAMBASE;
    assign off_even  = (bus.req_word ? a1 : bus.req_addr) - RAMBASE;
    assign addr_odd  = 15'(AW'(off_odd >> 1));
    assign addr_even = 15'(AW'(off_even >> 1));

`ifdef RAM_RANGE_CHECK_EN
    logic [16:0] last;
    // 17 bits so a word at 0xffff cannot wrap back into range
    assign last         = {1'b0, bus.req_addr} + 17'(bus.req_word);
    assign err          = (bus.req_addr < RAMBASE) || (last > 17'h03fff);
    assign bus.resp_err = !reset && s1_q.valid && s1_q.err;
`else
    assign err = 1'b0;
`endif

    assign write_en_even   = accept && bus.req_write && !err && (bus.req_word || !bus.req_addr[0]);
    assign write_en_odd    = accept && bus.req_write && !err && (bus.req_word || bus.req_addr[0]);
    assign write_addr_even = addr_even;
    assign write_addr_odd  = addr_odd;
    assign write_data_even = wsteer[7:0];
    assign write_data_odd  = wsteer[15:8];
    // holding the last address keeps bank outputs stable while a response stalls
    assign read_addr_even  = accept ? addr_even : hold_even_q;
    assign read_addr_odd   = accept ? addr_odd : hold_odd_q;
    assign bus.resp_valid  = !reset && s1_q.valid;

    ram_lane_steer u_wr_steer (
        .swap_i (bus.req_addr[0]),
        .word_i (1'b1),
        .kill_i (1'b0),
        .a_i    (bus.req_wdata[7:0]),
        .b_i    (bus.req_wdata[15:8]),
        .y_o    (wsteer)
    );

    ram_lane_steer u_rd_steer (
        .swap_i (s1_q.lsb),
        .word_i (s1_q.width == WORD),
        .kill_i (reset || !s1_q.valid || s1_q.write || s1_q.err),
        .a_i    (read_data_even),
        .b_i    (read_data_odd),
        .y_o    (bus.resp_rdata)
    );

    always_comb begin
        s1_d = s1_q;
        if (accept)
            s1_d = '{valid: 1'b1, write: bus.req_write, width: width_e'(bus.req_word),
                     lsb: bus.req_addr[0], err: err};
        else if (bus.resp_ready)
            s1_d.valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            hold_even_q <= '0;
            hold_odd_q  <= '0;
        end else begin
            s1_q <= s1_d;
            if (accept) begin
                hold_even_q <= addr_even;
                hold_odd_q  <= addr_odd;
            end
        end
    end
endmodule

// File: tb/tb_ram_access_unit.sv
// tb_ram_access_unit: directed self-checking bench for ram_access_unit (SIZE=1024, RAMBASE=0x3c00)
module tb_ram_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
    logic [7:0]  read_data_even, read_data_odd, write_data_even, write_data_odd;
    logic        write_en_even, write_en_odd;
    logic [7:0]  mem_e [32768];
    logic [7:0]  mem_o [32768];
    int          checks = 0;
    int          errors = 0;

    ram_access_unit_if bus ();

    ram_access_unit #(.SIZE(1024)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .read_addr_even  (read_addr_even),
        .read_addr_odd   (read_addr_odd),
        .read_data_even  (read_data_even),
        .read_data_odd   (read_data_odd),
        .write_addr_even (write_addr_even),
        .write_addr_odd  (write_addr_odd),
        .write_data_even (write_data_even),
        .write_data_odd  (write_data_odd),
        .write_en_even   (write_en_even),
        .write_en_odd    (write_en_odd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en_even) mem_e[write_addr_even] <= write_data_even;
        if (write_en_odd) mem_o[write_addr_odd] <= write_data_odd;
        read_data_even <= mem_e[read_addr_even];
        read_data_odd  <= mem_o[read_addr_odd];
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic w, input logic wd, input logic [15:0] d);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_word  = wd;
        bus.req_wdata = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        drive(1'b1, 16'h3c00, 1'b1, 1'b1, 16'hffff);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end
        checks++; if ({write_en_even, write_en_odd} !== 2'b00) begin errors++; $display("FAIL rst_write_en got %b exp 00", {write_en_even, write_en_odd}); end
        checks++; if (bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", bus.resp_rdata); end
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got %b exp 1", bus.req_ready); end
        checks++; if ({read_addr_even, read_addr_odd} !== 30'h0) begin errors++; $display("FAIL post_rst_hold got %h/%h exp 0/0", read_addr_even, read_addr_odd); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_resp_valid got %b exp 0", bus.resp_valid); end
        @(negedge clk);
    endtask

    task automatic test_aligned_word;
        drive(1'b1, 16'h3c00, 1'b1, 1'b1, 16'hbeef);
        #1;
        checks++; if ({write_en_even, write_en_odd} !== 2'b11) begin errors++; $display("FAIL t1_we got %b exp 11", {write_en_even, write_en_odd}); end
        checks++; if ({write_addr_even, write_addr_odd} !== {15'h000, 15'h000}) begin errors++; $display("FAIL t1_waddr got %h/%h exp 000/000", write_addr_even, write_addr_odd); end
        checks++; if ({write_data_even, write_data_odd} !== 16'hefbe) begin errors++; $display("FAIL t1_wdata got %h/%h exp ef/be", write_data_even, write_data_odd); end
        @(negedge clk);
        drive(1'b1, 16'h3c00, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t1_wr_resp got %b/%h exp 1/0000", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'hbeef) begin errors++; $display("FAIL t1_rd_resp got %b/%h exp 1/beef", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL t1_idle_valid got %b exp 0", bus.resp_valid); end
    endtask

    task automatic test_unaligned_word;
        drive(1'b1, 16'h3c01, 1'b1, 1'b1, 16'h1234);
        #1;
        checks++; if ({write_en_even, write_en_odd} !== 2'b11) begin errors++; $display("FAIL t2_we got %b exp 11", {write_en_even, write_en_odd}); end
        checks++; if ({write_addr_even, write_addr_odd} !== {15'h001, 15'h000}) begin errors++; $display("FAIL t2_waddr got %h/%h exp 001/000", write_addr_even, write_addr_odd); end
        checks++; if ({write_data_even, write_data_odd} !== 16'h1234) begin errors++; $display("FAIL t2_wdata got %h/%h exp 12/34", write_data_even, write_data_odd); end
        @(negedge clk);
        drive(1'b1, 16'h3c01, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t2_wr_resp got %h exp 0000", bus.resp_rdata); end
        @(negedge clk);
        drive(1'b1, 16'h3c01, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h1234) begin errors++; $display("FAIL t2_word_rd got %b/%h exp 1/1234", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h0034) begin errors++; $display("FAIL t2_byte_rd got %b/%h exp 1/0034", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] addrs [4] = '{16'h3c00, 16'h3c01, 16'h3c02, 16'h3c01};
        logic [15:0] exps  [4] = '{16'h00ef, 16'h0034, 16'h0012, 16'h0034};
        bus.resp_ready = 1'b0;
        drive(1'b1, 16'h3c00, 1'b0, 1'b1, 16'h0000);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h34ef) begin errors++; $display("FAIL t3_stall%0d got %b/%h exp 1/34ef", i, bus.resp_valid, bus.resp_rdata); end
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL t3_stall_ready%0d got %b exp 0", i, bus.req_ready); end
            checks++; if (read_addr_even !== 15'h000 || read_addr_odd !== 15'h000) begin errors++; $display("FAIL t3_hold%0d got %h/%h exp 000/000", i, read_addr_even, read_addr_odd); end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, addrs[i], 1'b0, 1'b0, 16'h0000);
            else drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            #1;
            if (i < 4) begin
                checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t3_b2b_ready%0d got %b exp 1", i, bus.req_ready); end
            end
            if (i > 0) begin
                checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exps[i-1]) begin errors++; $display("FAIL t3_b2b%0d got %b/%h exp 1/%h", i - 1, bus.resp_valid, bus.resp_rdata, exps[i-1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_read_after_write;
        drive(1'b1, 16'h3c10, 1'b1, 1'b1, 16'h55aa);
        #1;
        checks++; if ({write_en_even, write_en_odd} !== 2'b11 || write_addr_even !== 15'h008) begin errors++; $display("FAIL t4_we got %b/%h exp 11/008", {write_en_even, write_en_odd}, write_addr_even); end
        @(negedge clk);
        drive(1'b1, 16'h3c10, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t4_wr_resp got %h exp 0000", bus.resp_rdata); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h55aa) begin errors++; $display("FAIL t4_raw got %b/%h exp 1/55aa", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_boundary;
`ifdef RAM_RANGE_CHECK_EN
        drive(1'b1, 16'h3fff, 1'b1, 1'b1, 16'ha5c3);
        #1;
        checks++; if ({write_en_even, write_en_odd} !== 2'b00) begin errors++; $display("FAIL t5_oor_we got %b exp 00", {write_en_even, write_en_odd}); end
        @(negedge clk);
        drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t5_word_err got %b/%h exp 1/0000", bus.resp_err, bus.resp_rdata); end
        @(negedge clk);
        drive(1'b1, 16'h3c10, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t5_byte_err got %b/%b/%h exp 1/1/0000", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== 16'h55aa) begin errors++; $display("FAIL t5_in_range got %b/%h exp 0/55aa", bus.resp_err, bus.resp_rdata); end
        @(negedge clk);
`else
        drive(1'b1, 16'h3fff, 1'b1, 1'b1, 16'ha5c3);
        #1;
        checks++; if ({write_en_even, write_en_odd} !== 2'b11) begin errors++; $display("FAIL t5_wrap_we got %b exp 11", {write_en_even, write_en_odd}); end
        checks++; if ({write_addr_even, write_addr_odd} !== {15'h000, 15'h1ff}) begin errors++; $display("FAIL t5_wrap_waddr got %h/%h exp 000/1ff", write_addr_even, write_addr_odd); end
        checks++; if ({write_data_even, write_data_odd} !== 16'ha5c3) begin errors++; $display("FAIL t5_wrap_wdata got %h/%h exp a5/c3", write_data_even, write_data_odd); end
        @(negedge clk);
        drive(1'b1, 16'h3fff, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL t5_wr_resp got %h exp 0000", bus.resp_rdata); end
        @(negedge clk);
        drive(1'b1, 16'h3c00, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'ha5c3) begin errors++; $display("FAIL t5_wrap_rd got %b/%h exp 1/a5c3", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h00a5) begin errors++; $display("FAIL t5_alias_rd got %b/%h exp 1/00a5", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_stall;
        bus.resp_ready = 1'b0;
        drive(1'b1, 16'h3c10, 1'b0, 1'b1, 16'h0000);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h55aa) begin errors++; $display("FAIL t6_pending got %b/%h exp 1/55aa", bus.resp_valid, bus.resp_rdata); end
        reset = 1'b1;
        drive(1'b1, 16'h3c10, 1'b1, 1'b1, 16'h1111);
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL t6_in_rst got %b/%b exp 0/0", bus.resp_valid, bus.req_ready); end
        checks++; if ({write_en_even, write_en_odd} !== 2'b00) begin errors++; $display("FAIL t6_rst_we got %b exp 00", {write_en_even, write_en_odd}); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL t6_next got %b/%b exp 0/0", bus.resp_valid, bus.req_ready); end
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL t6_dropped got %b/%b exp 0/1", bus.resp_valid, bus.req_ready); end
        checks++; if (read_addr_even !== 15'h000 || read_addr_odd !== 15'h000) begin errors++; $display("FAIL t6_hold got %h/%h exp 000/000", read_addr_even, read_addr_odd); end
        bus.resp_ready = 1'b1;
        drive(1'b1, 16'h3c10, 1'b0, 1'b1, 16'h0000);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h55aa) begin errors++; $display("FAIL t6_after got %b/%h exp 1/55aa", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_aligned_word;
        test_unaligned_word;
        test_back_to_back;
        test_read_after_write;
        test_boundary;
        test_reset_stall;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
